// File: rtl/fir_decimate.sv
// Decimating real FIR: shifts DECIMATION samples into a tap history, then runs a
// one-tap-per-cycle MAC and pushes one sample downstream. Define FIR_DEQUANT_ROUND_EN for round-half-up dequantization.
module fir_decimate #(
    parameter int DATA_SIZE  = 32,
    parameter int BITS       = 10,
    parameter int NUM_TAPS   = 32,
    parameter int DECIMATION = 8,
    parameter logic [NUM_TAPS*DATA_SIZE-1:0] COEFFS = {NUM_TAPS{DATA_SIZE'(1024)}}
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_rd_en,
    input  logic                 in_empty,
    input  logic [DATA_SIZE-1:0] in_din,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [DATA_SIZE-1:0] out_dout
);

    localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CW = $clog2(DECIMATION + 1);
    localparam int AW = 2 * DATA_SIZE;

    typedef enum logic [1:0] {S_FILL, S_MAC, S_WRITE} state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CW-1:0]               r_count;
    logic [TW-1:0]               r_tap;
    logic signed [AW-1:0]        r_acc;
    logic signed [DATA_SIZE-1:0] r_hist [NUM_TAPS];
    logic [DATA_SIZE-1:0]        r_dout;

    logic signed [DATA_SIZE-1:0] w_coeff [NUM_TAPS];
    logic signed [AW-1:0]        w_hist_ext;
    logic signed [AW-1:0]        w_coeff_ext;
    logic signed [AW-1:0]        w_product;
    logic signed [AW-1:0]        w_acc_sum;
    logic signed [AW-1:0]        w_round;
    logic                        w_accept;
    logic                        w_last_sample;
    logic                        w_last_tap;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coeff
        assign w_coeff[g] = COEFFS[g*DATA_SIZE +: DATA_SIZE];
    end

    assign w_accept      = (r_state == S_FILL) && !in_empty;
    assign w_last_sample = (r_count == CW'(DECIMATION - 1));
    assign w_last_tap    = (r_tap == TW'(NUM_TAPS - 1));

    // Both operands sign-extended to the accumulator width so the product is exact.
    assign w_hist_ext  = {{DATA_SIZE{r_hist[r_tap][DATA_SIZE-1]}}, r_hist[r_tap]};
    assign w_coeff_ext = {{DATA_SIZE{w_coeff[r_tap][DATA_SIZE-1]}}, w_coeff[r_tap]};
    assign w_product   = w_hist_ext * w_coeff_ext;
    assign w_acc_sum   = r_acc + w_product;

`ifdef FIR_DEQUANT_ROUND_EN
    assign w_round = w_acc_sum + (AW'(1) << (BITS - 1));
`else
    assign w_round = w_acc_sum;
`endif

    assign in_rd_en  = !reset && w_accept;
    assign out_wr_en = !reset && (r_state == S_WRITE) && !out_full;
    assign out_dout  = r_dout;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL:  if (!in_empty && w_last_sample) w_next_state = S_MAC;
            S_MAC:   if (w_last_tap) w_next_state = S_WRITE;
            S_WRITE: if (!out_full) w_next_state = S_FILL;
            default: w_next_state = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_next_state;
    end

    // NOTE: the history memory is reset on purpose so post-reset outputs never see stale samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            for (int k = 0; k < NUM_TAPS; k++) r_hist[k] <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (!in_empty) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
                        r_hist[0] <= in_din;
                        if (w_last_sample) begin
                            r_count <= '0;
                            r_acc   <= '0;
                            r_tap   <= '0;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_sum;
                    r_tap <= r_tap + TW'(1);
                    if (w_last_tap) r_dout <= DATA_SIZE'(w_round >>> BITS);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimate.sv
// Directed, table-driven bench for fir_decimate: output sequences, backpressure,
// input stalls, unity-coefficient dequantization and mid-operation reset.
module tb_fir_decimate;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_rd_en, in_empty, out_wr_en, out_full;
    logic [31:0] in_din, out_dout;
    logic        in_rd_en2, out_wr_en2;
    logic [31:0] out_dout2;

    always #5 clock = ~clock;

    fir_decimate u_dut (
        .clock(clock), .reset(reset),
        .in_rd_en(in_rd_en), .in_empty(in_empty), .in_din(in_din),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_dout(out_dout)
    );

    fir_decimate #(.COEFFS({32{32'sd1}})) u_dut_unit (
        .clock(clock), .reset(reset),
        .in_rd_en(in_rd_en2), .in_empty(1'b0), .in_din(32'd100),
        .out_wr_en(out_wr_en2), .out_full(1'b0), .out_dout(out_dout2)
    );

    typedef struct {
        int din;
        int idx;
        int exp;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;
    int   src_q[$];
    int   got_q[$];
    int   accepted;
    int   rd_viol = 0;
    logic toggle_en = 1'b0;
    logic phase = 1'b0;
    logic got2_valid;
    int   got2;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_src();
        in_empty = (src_q.size() == 0) || (toggle_en && phase);
        in_din   = (src_q.size() != 0) ? src_q[0] : 32'd0;
    endtask

    always @(posedge clock) begin
        if (in_rd_en) begin
            if (in_empty) rd_viol++;
            else begin
                void'(src_q.pop_front());
                accepted++;
            end
        end
        if (out_wr_en) got_q.push_back(int'(out_dout));
        if (out_wr_en2 && !got2_valid) begin
            got2       = int'(out_dout2);
            got2_valid = 1'b1;
        end
        #1;
        phase = ~phase;
        drive_src();
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        src_q.delete();
        got_q.delete();
        accepted   = 0;
        got2_valid = 1'b0;
        drive_src();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push_n(input int n, input int val);
        @(negedge clock);
        for (int i = 0; i < n; i++) src_q.push_back(val);
        drive_src();
    endtask

    task automatic wait_outputs(input int n, input string name);
        int c = 0;
        while (got_q.size() < n && c < 3000) begin
            @(negedge clock);
            c++;
        end
        if (got_q.size() < n) check({name, " timeout"}, got_q.size(), n);
    endtask

    task automatic compare_table(input int base, input string name);
        for (int i = base; i < base + 8; i++) begin
            if (vecs[i].idx < got_q.size())
                check($sformatf("%s out[%0d] din=%0d", name, vecs[i].idx, vecs[i].din),
                      got_q[vecs[i].idx], vecs[i].exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i]     = '{din: 1024,  idx: i, exp: (i < 3) ? 8192 * (i + 1) : 32768};
            vecs[i + 8] = '{din: -1024, idx: i, exp: (i < 3) ? -8192 * (i + 1) : -32768};
        end
        reset    = 1'b1;
        out_full = 1'b0;
        drive_src();

        // Reset state, with the unity-coefficient instance seeing a non-empty FIFO.
        do_reset();
        reset = 1'b1;
        @(negedge clock);
        check("reset out_dout", out_dout, 0);
        check("reset out_wr_en", out_wr_en, 0);
        check("reset in_rd_en forced", in_rd_en2, 0);
        reset = 1'b0;

        // Unity taps, 8 x 100 -> 800 dequantized.
        begin
            int c = 0;
            while (!got2_valid && c < 200) begin
                @(negedge clock);
                c++;
            end
`ifdef FIR_DEQUANT_ROUND_EN
            check("unity taps dequant", got2_valid ? got2 : -1, 1);
`else
            check("unity taps dequant", got2_valid ? got2 : -1, 0);
`endif
        end

        // Positive and negative ramps into steady state.
        do_reset();
        push_n(64, 1024);
        wait_outputs(8, "pos");
        compare_table(0, "pos");
        repeat (60) @(negedge clock);
        check("pos no extra writes", got_q.size(), 8);

        do_reset();
        push_n(64, -1024);
        wait_outputs(8, "neg");
        compare_table(8, "neg");

        // Input stalls every other cycle.
        do_reset();
        rd_viol   = 0;
        toggle_en = 1'b1;
        push_n(64, 1024);
        wait_outputs(8, "toggle");
        compare_table(0, "toggle");
        check("rd while empty", rd_viol, 0);
        toggle_en = 1'b0;

        // Output backpressure at the first write.
        do_reset();
        out_full = 1'b1;
        push_n(64, 1024);
        repeat (60) @(negedge clock);
        begin
            int wr_hi = 0, rd_hi = 0, dout_bad = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clock);
                if (out_wr_en) wr_hi++;
                if (in_rd_en) rd_hi++;
                if (out_dout !== 32'd8192) dout_bad++;
            end
            check("hold out_wr_en cycles", wr_hi, 0);
            check("hold in_rd_en cycles", rd_hi, 0);
            check("hold out_dout unstable", dout_bad, 0);
            check("hold reads before release", accepted, 8);
        end
        out_full = 1'b0;
        @(negedge clock);
        check("release one write", got_q.size(), 1);
        repeat (3) @(negedge clock);
        check("release reads resume", accepted > 8, 1);
        wait_outputs(8, "bp");
        compare_table(0, "bp");

        // Reset at MAC tap 10 drops the pending output and clears history.
        do_reset();
        push_n(8, 1024);
        begin
            int c = 0;
            while (accepted < 8 && c < 100) begin
                @(negedge clock);
                c++;
            end
            check("mid reset fill count", accepted, 8);
        end
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check("mid reset no write", got_q.size(), 0);
        push_n(8, 1024);
        wait_outputs(1, "post reset");
        if (got_q.size() > 0) check("post reset out", got_q[0], 8192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
